// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: RV opcodes, instruction format
// classes and the decode payload carried across the ID/EX register.
package decode_pkg;

  localparam int unsigned OPC_W  = 7;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned F7_W   = 7;
  localparam int unsigned INSN_W = 32;

  localparam logic [OPC_W-1:0] OPC_LUI       = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL       = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR      = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE     = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP        = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [OPC_W-1:0] OPC_OP_32     = 7'b0111011;
  localparam logic [OPC_W-1:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [OPC_W-1:0] OPC_FENCE     = 7'b0001111;

  localparam logic [F7_W-1:0] F7_BASE   = 7'b0000000;
  localparam logic [F7_W-1:0] F7_ALT    = 7'b0100000;
  localparam logic [F7_W-1:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  // Width-independent part of the decode result (PC and immediate are
  // parameter-sized and live beside it in the stage register).
  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [F3_W-1:0]  func3;
    logic [F7_W-1:0]  func7;
    logic [OPC_W-1:0] opcode;
    fmt_e             fmt;
    logic             rs1_used;
    logic             rs2_used;
    logic             rd_we;
    logic             illegal;
  } dec_t;

  localparam dec_t DEC_BUBBLE = '{
    rs1:      5'd0,
    rs2:      5'd0,
    rd:       5'd0,
    func3:    3'd0,
    func7:    7'd0,
    opcode:   7'd0,
    fmt:      FMT_NONE,
    rs1_used: 1'b0,
    rs2_used: 1'b0,
    rd_we:    1'b0,
    illegal:  1'b0
  };

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational immediate extraction, sign-extended to XLEN.
// Ports: instr (32b instruction word), fmt (format class), imm (XLEN).
// R-type and NONE yield zero.
module imm_gen
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;
  logic        unused_opcode;

  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm32 = 32'd0;
    case (fmt)
      FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      FMT_U: imm32 = {instr[31:12], 12'd0};
      FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  // Signed cast so widening to 64 replicates bit 31.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I decoder feeding the ID/EX boundary.
// Ports: clk, rstn (sync active-low); in_valid/in_instr/in_pc from IF;
// stall holds the register, flush loads a bubble; out_* is the registered
// decode (fields, imm, fmt, use flags, illegal) plus a decoded-instr count.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned SUPPORT_M = 0,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [PC_W-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_func3,
  output logic [6:0]       out_func7,
  output logic [6:0]       out_opcode,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_rs1_used,
  output logic             out_rs2_used,
  output logic             out_rd_we,
  output logic             out_illegal,
  output logic [CNT_W-1:0] out_count
);

  localparam bit IS_RV64 = (XLEN == 64);
  localparam bit HAS_M   = (SUPPORT_M != 0);

  logic [OPC_W-1:0] opcode_c;
  logic [F3_W-1:0]  func3_c;
  logic [F7_W-1:0]  func7_c;
  fmt_e             fmt_c;
  logic             legal_c;
  logic             is_fence_c;
  dec_t             dec_c;
  logic [XLEN-1:0]  imm_c;

  dec_t             dec_q;
  logic [XLEN-1:0]  imm_q;
  logic [PC_W-1:0]  pc_q;
  logic             valid_q;
  logic [CNT_W-1:0] count_q;

  assign opcode_c   = in_instr[6:0];
  assign func3_c    = in_instr[14:12];
  assign func7_c    = in_instr[31:25];
  assign is_fence_c = (opcode_c == OPC_FENCE);

  // Opcode -> format class, then the func7/func3 legality screen for R-type.
  always_comb begin
    fmt_c   = FMT_NONE;
    legal_c = 1'b0;
    case (opcode_c)
      OPC_LUI, OPC_AUIPC: begin
        fmt_c = FMT_U; legal_c = 1'b1;
      end
      OPC_JAL: begin
        fmt_c = FMT_J; legal_c = 1'b1;
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM, OPC_FENCE: begin
        fmt_c = FMT_I; legal_c = 1'b1;
      end
      OPC_STORE: begin
        fmt_c = FMT_S; legal_c = 1'b1;
      end
      OPC_BRANCH: begin
        fmt_c = FMT_B; legal_c = 1'b1;
      end
      OPC_OP: begin
        fmt_c = FMT_R; legal_c = 1'b1;
      end
      OPC_OP_IMM_32: begin
        fmt_c = FMT_I; legal_c = IS_RV64;
      end
      OPC_OP_32: begin
        fmt_c = FMT_R; legal_c = IS_RV64;
      end
      default: begin
        fmt_c = FMT_NONE; legal_c = 1'b0;
      end
    endcase

    if (fmt_c == FMT_R) begin
      if (!((func7_c == F7_BASE) || (func7_c == F7_ALT) ||
            (HAS_M && (func7_c == F7_MULDIV)))) begin
        legal_c = 1'b0;
      end
      // Only ADD/SUB and SRL/SRA have an alternate encoding.
      if ((func7_c == F7_ALT) && (func3_c != 3'b000) && (func3_c != 3'b101)) begin
        legal_c = 1'b0;
      end
    end

    if (in_instr[1:0] != 2'b11) begin
      legal_c = 1'b0;
    end

    if (!legal_c) begin
      fmt_c = FMT_NONE;
    end
  end

  // Assemble the payload; use flags follow the (legality-screened) format.
  always_comb begin
    dec_c          = DEC_BUBBLE;
    dec_c.rs1      = in_instr[19:15];
    dec_c.rs2      = in_instr[24:20];
    dec_c.rd       = in_instr[11:7];
    dec_c.func3    = func3_c;
    dec_c.func7    = func7_c;
    dec_c.opcode   = opcode_c;
    dec_c.fmt      = fmt_c;
    dec_c.illegal  = !legal_c;
    dec_c.rs1_used = ((fmt_c == FMT_R) || (fmt_c == FMT_I) ||
                      (fmt_c == FMT_S) || (fmt_c == FMT_B)) && !is_fence_c;
    dec_c.rs2_used = (fmt_c == FMT_R) || (fmt_c == FMT_S) || (fmt_c == FMT_B);
    dec_c.rd_we    = ((fmt_c == FMT_R) || (fmt_c == FMT_I) ||
                      (fmt_c == FMT_U) || (fmt_c == FMT_J)) && !is_fence_c &&
                     (in_instr[11:7] != 5'd0) && in_valid;
  end

  imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr (in_instr),
    .fmt   (fmt_c),
    .imm   (imm_c)
  );

  // ID/EX register: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dec_q   <= DEC_BUBBLE;
      imm_q   <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else if (flush) begin
      dec_q   <= DEC_BUBBLE;
      imm_q   <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      dec_q   <= dec_c;
      imm_q   <= imm_c;
      pc_q    <= in_pc;
      valid_q <= in_valid;
      if (in_valid) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_rs1      = dec_q.rs1;
  assign out_rs2      = dec_q.rs2;
  assign out_rd       = dec_q.rd;
  assign out_func3    = dec_q.func3;
  assign out_func7    = dec_q.func7;
  assign out_opcode   = dec_q.opcode;
  assign out_imm      = imm_q;
  assign out_fmt      = dec_q.fmt;
  assign out_rs1_used = dec_q.rs1_used;
  assign out_rs2_used = dec_q.rs2_used;
  assign out_rd_we    = dec_q.rd_we;
  assign out_illegal  = dec_q.illegal;
  assign out_count    = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: three instances (RV32, RV64, RV32+M) share one
// stimulus stream; a behavioural model predicts every output each cycle,
// and directed literal checks pin the model on hand-decoded instructions.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        stall;
  logic        flush;

  logic        o_valid [3];
  logic [31:0] o_pc    [3];
  logic [4:0]  o_rs1   [3];
  logic [4:0]  o_rs2   [3];
  logic [4:0]  o_rd    [3];
  logic [2:0]  o_f3    [3];
  logic [6:0]  o_f7    [3];
  logic [6:0]  o_op    [3];
  logic [2:0]  o_fmt   [3];
  logic        o_rs1u  [3];
  logic        o_rs2u  [3];
  logic        o_rdwe  [3];
  logic        o_ill   [3];
  logic [31:0] o_cnt   [3];
  logic [31:0] imm_a;
  logic [63:0] imm_b;
  logic [31:0] imm_c;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  bit          started  = 1'b0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .PC_W(32), .SUPPORT_M(0), .CNT_W(32)) d32 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_instr(in_instr),
    .in_pc(in_pc), .stall(stall), .flush(flush),
    .out_valid(o_valid[0]), .out_pc(o_pc[0]), .out_rs1(o_rs1[0]),
    .out_rs2(o_rs2[0]), .out_rd(o_rd[0]), .out_func3(o_f3[0]),
    .out_func7(o_f7[0]), .out_opcode(o_op[0]), .out_imm(imm_a),
    .out_fmt(o_fmt[0]), .out_rs1_used(o_rs1u[0]), .out_rs2_used(o_rs2u[0]),
    .out_rd_we(o_rdwe[0]), .out_illegal(o_ill[0]), .out_count(o_cnt[0]));

  decode_stage #(.XLEN(64), .PC_W(32), .SUPPORT_M(0), .CNT_W(32)) d64 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_instr(in_instr),
    .in_pc(in_pc), .stall(stall), .flush(flush),
    .out_valid(o_valid[1]), .out_pc(o_pc[1]), .out_rs1(o_rs1[1]),
    .out_rs2(o_rs2[1]), .out_rd(o_rd[1]), .out_func3(o_f3[1]),
    .out_func7(o_f7[1]), .out_opcode(o_op[1]), .out_imm(imm_b),
    .out_fmt(o_fmt[1]), .out_rs1_used(o_rs1u[1]), .out_rs2_used(o_rs2u[1]),
    .out_rd_we(o_rdwe[1]), .out_illegal(o_ill[1]), .out_count(o_cnt[1]));

  decode_stage #(.XLEN(32), .PC_W(32), .SUPPORT_M(1), .CNT_W(32)) dm (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_instr(in_instr),
    .in_pc(in_pc), .stall(stall), .flush(flush),
    .out_valid(o_valid[2]), .out_pc(o_pc[2]), .out_rs1(o_rs1[2]),
    .out_rs2(o_rs2[2]), .out_rd(o_rd[2]), .out_func3(o_f3[2]),
    .out_func7(o_f7[2]), .out_opcode(o_op[2]), .out_imm(imm_c),
    .out_fmt(o_fmt[2]), .out_rs1_used(o_rs1u[2]), .out_rs2_used(o_rs2u[2]),
    .out_rd_we(o_rdwe[2]), .out_illegal(o_ill[2]), .out_count(o_cnt[2]));

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7, op;
    logic [63:0] imm;
    int          fmt;
    logic        rs1u, rs2u, rdwe, ill;
    logic [31:0] cnt;
  } exp_t;

  exp_t mdl [3];

  function automatic exp_t bubble(input logic [31:0] cnt);
    exp_t e;
    e.valid = 0; e.pc = 0; e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.f3 = 0;
    e.f7 = 0; e.op = 0; e.imm = 0; e.fmt = 7; e.rs1u = 0; e.rs2u = 0;
    e.rdwe = 0; e.ill = 0; e.cnt = cnt;
    return e;
  endfunction

  // What the decode of word w must be, straight from the ISA tables.
  function automatic exp_t decode_m(input logic [31:0] w, input logic [31:0] pc,
                                    input logic v, input bit is64, input bit m);
    exp_t e;
    int   fmt;
    logic [6:0] op = w[6:0];
    case (op)
      7'h37, 7'h17:                      fmt = 4;
      7'h6F:                             fmt = 5;
      7'h67, 7'h03, 7'h13, 7'h73, 7'h0F: fmt = 1;
      7'h23:                             fmt = 2;
      7'h63:                             fmt = 3;
      7'h33:                             fmt = 0;
      7'h3B:                             fmt = is64 ? 0 : 7;
      7'h1B:                             fmt = is64 ? 1 : 7;
      default:                           fmt = 7;
    endcase
    if (fmt == 0) begin
      if (!(w[31:25] == 7'h00 || w[31:25] == 7'h20 || (m && w[31:25] == 7'h01)))
        fmt = 7;
      if (w[31:25] == 7'h20 && w[14:12] != 3'd0 && w[14:12] != 3'd5)
        fmt = 7;
    end
    if (w[1:0] != 2'b11) fmt = 7;

    e.valid = v; e.pc = pc; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
    e.f3 = w[14:12]; e.f7 = w[31:25]; e.op = op; e.fmt = fmt; e.ill = (fmt == 7);
    case (fmt)
      1: e.imm = {{52{w[31]}}, w[31:20]};
      2: e.imm = {{52{w[31]}}, w[31:25], w[11:7]};
      3: e.imm = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      4: e.imm = {{32{w[31]}}, w[31:12], 12'd0};
      5: e.imm = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: e.imm = 64'd0;
    endcase
    e.rs1u = (fmt <= 3) && (op != 7'h0F);
    e.rs2u = (fmt == 0) || (fmt == 2) || (fmt == 3);
    e.rdwe = (fmt == 0 || fmt == 1 || fmt == 4 || fmt == 5) && (op != 7'h0F) &&
             (w[11:7] != 5'd0) && v;
    e.cnt  = 0;
    return e;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rstn) begin
        mdl[k] <= bubble(32'd0);
      end else if (flush) begin
        mdl[k] <= bubble(mdl[k].cnt);
      end else if (!stall) begin
        exp_t e;
        e = decode_m(in_instr, in_pc, in_valid, k == 1, k == 2);
        e.cnt = mdl[k].cnt + (in_valid ? 32'd1 : 32'd0);
        mdl[k] <= e;
      end
    end
    if (!rstn) started <= 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output of every instance against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        logic [63:0] ia, ie;
        string p;
        p  = $sformatf("m%0d_", k);
        ia = (k == 1) ? imm_b : {32'd0, (k == 0) ? imm_a : imm_c};
        ie = (k == 1) ? mdl[k].imm : {32'd0, mdl[k].imm[31:0]};
        chk({p, "valid"}, 64'(o_valid[k]), 64'(mdl[k].valid));
        chk({p, "pc"},    64'(o_pc[k]),    64'(mdl[k].pc));
        chk({p, "rs1"},   64'(o_rs1[k]),   64'(mdl[k].rs1));
        chk({p, "rs2"},   64'(o_rs2[k]),   64'(mdl[k].rs2));
        chk({p, "rd"},    64'(o_rd[k]),    64'(mdl[k].rd));
        chk({p, "func3"}, 64'(o_f3[k]),    64'(mdl[k].f3));
        chk({p, "func7"}, 64'(o_f7[k]),    64'(mdl[k].f7));
        chk({p, "opcode"},64'(o_op[k]),    64'(mdl[k].op));
        chk({p, "imm"},   ia,              ie);
        chk({p, "fmt"},   64'(o_fmt[k]),   64'(mdl[k].fmt));
        chk({p, "rs1u"},  64'(o_rs1u[k]),  64'(mdl[k].rs1u));
        chk({p, "rs2u"},  64'(o_rs2u[k]),  64'(mdl[k].rs2u));
        chk({p, "rdwe"},  64'(o_rdwe[k]),  64'(mdl[k].rdwe));
        chk({p, "ill"},   64'(o_ill[k]),   64'(mdl[k].ill));
        chk({p, "count"}, 64'(o_cnt[k]),   64'(mdl[k].cnt));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] SW   = 32'hFE11_2E23;
  localparam logic [31:0] BEQ  = 32'hFE00_0CE3;
  localparam logic [31:0] LUI  = 32'h1234_52B7;
  localparam logic [31:0] MUL  = 32'h0220_8033;

  task automatic step(input logic r, input logic v, input logic [31:0] i,
                      input logic [31:0] p, input logic st, input logic fl);
    rstn = r; in_valid = v; in_instr = i; in_pc = p; stall = st; flush = fl;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] extra [5];
    extra[0] = 32'h0080_00EF;  // jal x1, 8
    extra[1] = 32'h0000_008F;  // fence, rd field = x1
    extra[2] = 32'h4020_9033;  // OP func7=0100000 func3=001
    extra[3] = 32'h0050_0091;  // low bits 01
    extra[4] = 32'h4010_D093;  // srai x1, x1, 1

    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("rst_fmt", 64'(o_fmt[0]), 64'd7);
    chk("rst_valid", 64'(o_valid[0]), 64'd0);
    chk("rst_count", 64'(o_cnt[0]), 64'd0);

    step(1'b1, 1'b1, ADDI, 32'h100, 1'b0, 1'b0);
    chk("addi_rd", 64'(o_rd[0]), 64'd1);
    chk("addi_rs1", 64'(o_rs1[0]), 64'd0);
    chk("addi_imm", 64'(imm_a), 64'd5);
    chk("addi_fmt", 64'(o_fmt[0]), 64'd1);
    chk("addi_rdwe", 64'(o_rdwe[0]), 64'd1);
    chk("addi_rs1u", 64'(o_rs1u[0]), 64'd1);
    chk("addi_pc", 64'(o_pc[0]), 64'h100);
    chk("addi_count", 64'(o_cnt[0]), 64'd1);

    step(1'b1, 1'b1, SW, 32'h104, 1'b0, 1'b0);
    chk("sw_imm", 64'(imm_a), 64'hFFFF_FFFC);
    chk("sw_imm64", imm_b, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("sw_fmt", 64'(o_fmt[0]), 64'd2);
    chk("sw_rdwe", 64'(o_rdwe[0]), 64'd0);
    chk("sw_use", 64'({o_rs1u[0], o_rs2u[0]}), 64'd3);

    step(1'b1, 1'b1, BEQ, 32'h108, 1'b0, 1'b0);
    chk("beq_imm", 64'(imm_a), 64'hFFFF_FFF8);
    chk("beq_fmt", 64'(o_fmt[0]), 64'd3);

    step(1'b1, 1'b1, LUI, 32'h10C, 1'b0, 1'b0);
    chk("lui_imm", 64'(imm_a), 64'h1234_5000);
    chk("lui_fmt", 64'(o_fmt[0]), 64'd4);
    chk("lui_rd", 64'(o_rd[0]), 64'd5);

    step(1'b1, 1'b1, ADDI, 32'h110, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b1, 1'b1, LUI, 32'h114, 1'b1, 1'b0);
    chk("stall_imm", 64'(imm_a), 64'd5);
    chk("stall_pc", 64'(o_pc[0]), 64'h110);
    chk("stall_count", 64'(o_cnt[0]), 64'd5);

    step(1'b1, 1'b1, LUI, 32'h114, 1'b1, 1'b1);
    chk("flush_valid", 64'(o_valid[0]), 64'd0);
    chk("flush_fmt", 64'(o_fmt[0]), 64'd7);
    chk("flush_count", 64'(o_cnt[0]), 64'd5);

    step(1'b1, 1'b1, 32'h0000_0000, 32'h200, 1'b0, 1'b0);
    chk("zero_ill", 64'(o_ill[0]), 64'd1);
    chk("zero_fmt", 64'(o_fmt[0]), 64'd7);
    chk("zero_valid", 64'(o_valid[0]), 64'd1);

    step(1'b1, 1'b1, 32'h0000_003B, 32'h204, 1'b0, 1'b0);
    chk("op32_ill32", 64'(o_ill[0]), 64'd1);
    chk("op32_fmt32", 64'(o_fmt[0]), 64'd7);
    chk("op32_rdwe32", 64'(o_rdwe[0]), 64'd0);
    chk("op32_fmt64", 64'(o_fmt[1]), 64'd0);
    chk("op32_ill64", 64'(o_ill[1]), 64'd0);

    step(1'b1, 1'b1, MUL, 32'h208, 1'b0, 1'b0);
    chk("mul_ill_nom", 64'(o_ill[0]), 64'd1);
    chk("mul_fmt_m", 64'(o_fmt[2]), 64'd0);
    chk("mul_rdwe_m", 64'(o_rdwe[2]), 64'd0);

    for (int j = 0; j < 5; j++) step(1'b1, 1'b1, extra[j], 32'h300 + 32'(4 * j), 1'b0, 1'b0);
    chk("srai_fmt", 64'(o_fmt[0]), 64'd1);

    step(1'b1, 1'b0, ADDI, 32'h400, 1'b0, 1'b0);
    chk("inv_valid", 64'(o_valid[0]), 64'd0);
    chk("inv_rdwe", 64'(o_rdwe[0]), 64'd0);
    chk("inv_count", 64'(o_cnt[0]), 64'd13);

    for (int j = 0; j < 4; j++) step(1'b1, 1'b1, ADDI, 32'h500 + 32'(4 * j), 1'b0, 1'b0);
    chk("pre_rst_count", 64'(o_cnt[0]), 64'd17);
    step(1'b1, 1'b1, LUI, 32'h600, 1'b1, 1'b0);
    step(1'b0, 1'b1, LUI, 32'h600, 1'b1, 1'b0);
    chk("rst_stall_fmt", 64'(o_fmt[0]), 64'd7);
    chk("rst_stall_valid", 64'(o_valid[0]), 64'd0);
    chk("rst_stall_count", 64'(o_cnt[0]), 64'd0);
    chk("rst_stall_imm", 64'(imm_a), 64'd0);

    step(1'b1, 1'b0, ADDI, 32'h700, 1'b0, 1'b0);
    chk("inv_after_rst_count", 64'(o_cnt[0]), 64'd0);
    step(1'b1, 1'b0, ADDI, 32'h700, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
